// File: rtl/store_buffer_pkg.sv
// Shared widths, default sizing and bus types for the store buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package store_buffer_pkg;

    localparam int RV32_ADDR_WIDTH = 32;
    localparam int RV32_DATA_WIDTH = 32;

    // Default sizing: 4 entries, 2-bit pointers.
    localparam int DEF_STBUF_DEPTH = 4;
    localparam int DEF_STBUF_SEL   = 2;

    typedef logic [RV32_ADDR_WIDTH-1:0] addr_t;
    typedef logic [RV32_DATA_WIDTH-1:0] data_t;

endpackage

// File: rtl/store_buffer_if.sv
// Store buffer bus: ldst allocate, ROB commit/kill, load forwarding, dmem drain.
// Latency: n/a (signal bundle).
// Backpressure: o_stbuf_full stalls the ldst unit; i_dmem_occupy holds off the drain.
// Ports: master = ldst/ROB/dmem side driving i_* and sampling o_*; slave = store buffer.
interface store_buffer_if;
    import store_buffer_pkg::*;

    logic       i_exfin_st;
    addr_t      i_exfin_st_addr;
    data_t      i_exfin_st_data;
    logic       o_stbuf_full;
    logic [1:0] i_com_st_num;
    logic       i_kill;
    addr_t      i_ld_addr;
    logic       o_stbuf_addr_hit;
    data_t      o_stbuf_rd_data;
    logic       i_dmem_occupy;
    logic       o_dmem_we;
    addr_t      o_dmem_wr_addr;
    data_t      o_dmem_wr_data;

    modport master (
        output i_exfin_st, i_exfin_st_addr, i_exfin_st_data, i_com_st_num, i_kill,
               i_ld_addr, i_dmem_occupy,
        input  o_stbuf_full, o_stbuf_addr_hit, o_stbuf_rd_data, o_dmem_we,
               o_dmem_wr_addr, o_dmem_wr_data
    );

    modport slave (
        input  i_exfin_st, i_exfin_st_addr, i_exfin_st_data, i_com_st_num, i_kill,
               i_ld_addr, i_dmem_occupy,
        output o_stbuf_full, o_stbuf_addr_hit, o_stbuf_rd_data, o_dmem_we,
               o_dmem_wr_addr, o_dmem_wr_data
    );

endinterface

// File: rtl/store_buffer_fwd_search.sv
// Age-ordered address match over the store buffer entries; youngest valid match wins.
// Latency: purely combinational.
// Backpressure: none.
// Ports: vld/addr = entry array, tail = next free slot, ld_addr = lookup; hit/idx = result.
module store_buffer_fwd_search
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = DEF_STBUF_DEPTH,
    parameter int SEL   = DEF_STBUF_SEL
) (
    input  logic [DEPTH-1:0] vld,
    input  addr_t            addr [DEPTH],
    input  logic [SEL-1:0]   tail,
    input  addr_t            ld_addr,
    output logic             hit,
    output logic [SEL-1:0]   idx
);

    logic [SEL-1:0] pos;

    // Walk from tail-DEPTH (oldest possible slot) up to tail-1 so the last
    // match written is the youngest one. Invalid slots never match, so the
    // walk does not need to know where head is.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        pos = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            pos = tail - SEL'(k);
            if (vld[pos] && (addr[pos] == ld_addr)) begin
                hit = 1'b1;
                idx = pos;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Circular store buffer: holds finished stores until commit, drains committed ones to dmem in order.
// Latency: allocate/commit take effect next cycle; forwarding and drain request are combinational.
// Backpressure: o_stbuf_full stalls allocation; drain waits while i_dmem_occupy is high.
// Ports: clk, rst_n (async active-low), bus (store_buffer_if.slave).
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int STBUF_DEPTH = DEF_STBUF_DEPTH,
    parameter int STBUF_SEL   = DEF_STBUF_SEL
) (
    input  logic          clk,
    input  logic          rst_n,
    store_buffer_if.slave bus
);

    localparam int CW = STBUF_SEL + 1;

    logic [STBUF_DEPTH-1:0] vld;
    logic [STBUF_DEPTH-1:0] com;
    logic [STBUF_DEPTH-1:0] com_set;
    addr_t                  ent_addr [STBUF_DEPTH];
    data_t                  ent_data [STBUF_DEPTH];

    logic [STBUF_SEL-1:0] head;
    logic [STBUF_SEL-1:0] com_ptr;
    logic [STBUF_SEL-1:0] com_ptr_nxt;
    logic [STBUF_SEL-1:0] tail;
    logic [STBUF_SEL-1:0] fwd_idx;
    // cnt = valid entries; ccnt = committed entries, which is what survives a kill.
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        ccnt;
    logic [CW-1:0]        ccnt_nxt;

    logic full;
    logic alloc;
    logic drain;
    logic fwd_hit;

    assign full        = (cnt == CW'(STBUF_DEPTH));
    assign alloc       = bus.i_exfin_st & ~full & ~bus.i_kill;
    assign drain       = vld[head] & com[head] & ~bus.i_dmem_occupy;
    assign com_ptr_nxt = com_ptr + STBUF_SEL'(bus.i_com_st_num);
    assign ccnt_nxt    = ccnt + CW'(bus.i_com_st_num) - CW'(drain);

    // Slots com_ptr .. com_ptr+i_com_st_num-1 (mod depth) commit this cycle.
    always_comb begin
        com_set = '0;
        for (int i = 0; i < STBUF_DEPTH; i++) begin
            com_set[i] = ({2'b00, STBUF_SEL'(i) - com_ptr} <
                          {STBUF_SEL'(0), bus.i_com_st_num});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            com <= '0;
            for (int i = 0; i < STBUF_DEPTH; i++) begin
                ent_addr[i] <= '0;
                ent_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STBUF_DEPTH; i++) begin
                if (drain && (head == STBUF_SEL'(i))) begin
                    vld[i] <= 1'b0;
                    com[i] <= 1'b0;
                end else if (alloc && (tail == STBUF_SEL'(i))) begin
                    vld[i]      <= 1'b1;
                    com[i]      <= 1'b0;
                    ent_addr[i] <= bus.i_exfin_st_addr;
                    ent_data[i] <= bus.i_exfin_st_data;
                end else begin
                    if (com_set[i]) begin
                        com[i] <= 1'b1;
                    end
                    // Commit lands before the kill, so same-cycle commits survive.
                    if (bus.i_kill && !com[i] && !com_set[i]) begin
                        vld[i] <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head    <= '0;
            com_ptr <= '0;
            tail    <= '0;
            cnt     <= '0;
            ccnt    <= '0;
        end else begin
            head    <= head + STBUF_SEL'(drain);
            com_ptr <= com_ptr_nxt;
            ccnt    <= ccnt_nxt;
            if (bus.i_kill) begin
                tail <= com_ptr_nxt;
                cnt  <= ccnt_nxt;
            end else begin
                tail <= tail + STBUF_SEL'(alloc);
                cnt  <= cnt + CW'(alloc) - CW'(drain);
            end
        end
    end

    store_buffer_fwd_search #(
        .DEPTH (STBUF_DEPTH),
        .SEL   (STBUF_SEL)
    ) u_fwd (
        .vld     (vld),
        .addr    (ent_addr),
        .tail    (tail),
        .ld_addr (bus.i_ld_addr),
        .hit     (fwd_hit),
        .idx     (fwd_idx)
    );

    assign bus.o_stbuf_full     = full;
    assign bus.o_stbuf_addr_hit = fwd_hit;
    assign bus.o_stbuf_rd_data  = fwd_hit ? ent_data[fwd_idx] : '0;
    assign bus.o_dmem_we        = drain;
    assign bus.o_dmem_wr_addr   = drain ? ent_addr[head] : '0;
    assign bus.o_dmem_wr_data   = drain ? ent_data[head] : '0;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: queue-based reference model plus per-cycle scoreboard.
// Latency: expectations are pushed when inputs are driven and popped on the following negedge.
// Backpressure: the model honours full (allocation ignored) and dmem occupancy (drain held).
module tb_store_buffer;
    import store_buffer_pkg::*;

    localparam int DEPTH = 4;

    logic clk;
    logic rst_n;

    store_buffer_if sbif ();

    store_buffer #(
        .STBUF_DEPTH (DEPTH),
        .STBUF_SEL   (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sbif.slave)
    );

    typedef struct {
        logic        full;
        logic        hit;
        logic [31:0] rd;
        logic        we;
        logic [31:0] wa;
        logic [31:0] wd;
        string       tag;
    } exp_t;

    exp_t        exp_q [$];
    // Reference model: the buffer is a program-ordered list; the first m_ncom are committed.
    logic [31:0] m_addr [$];
    logic [31:0] m_data [$];
    int          m_ncom;

    int checks = 0;
    int errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle_inputs();
        sbif.i_exfin_st      = 1'b0;
        sbif.i_exfin_st_addr = '0;
        sbif.i_exfin_st_data = '0;
        sbif.i_com_st_num    = 2'd0;
        sbif.i_kill          = 1'b0;
        sbif.i_ld_addr       = '0;
        sbif.i_dmem_occupy   = 1'b0;
    endtask

    task automatic rst_cycle(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        idle_inputs();
        e.full = 1'b0; e.hit = 1'b0; e.rd = '0; e.we = 1'b0; e.wa = '0; e.wd = '0;
        e.tag = tag;
        exp_q.push_back(e);
        m_addr.delete();
        m_data.delete();
        m_ncom = 0;
    endtask

    task automatic step(input logic st, input logic [31:0] a, input logic [31:0] d,
                        input int cn, input logic kl, input logic [31:0] la,
                        input logic occ, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n                = 1'b1;
        sbif.i_exfin_st      = st;
        sbif.i_exfin_st_addr = a;
        sbif.i_exfin_st_data = d;
        sbif.i_com_st_num    = 2'(cn);
        sbif.i_kill          = kl;
        sbif.i_ld_addr       = la;
        sbif.i_dmem_occupy   = occ;

        e.full = (m_addr.size() == DEPTH);
        e.hit  = 1'b0;
        e.rd   = '0;
        for (int j = m_addr.size() - 1; j >= 0; j--) begin
            if (m_addr[j] == la) begin
                e.hit = 1'b1;
                e.rd  = m_data[j];
                break;
            end
        end
        e.we = (m_ncom > 0) && !occ;
        e.wa = '0;
        e.wd = '0;
        if (e.we) begin
            e.wa = m_addr[0];
            e.wd = m_data[0];
        end
        e.tag = tag;
        exp_q.push_back(e);

        m_ncom += cn;
        if (e.we) begin
            void'(m_addr.pop_front());
            void'(m_data.pop_front());
            m_ncom--;
        end
        if (kl) begin
            while (m_addr.size() > m_ncom) begin
                void'(m_addr.pop_back());
                void'(m_data.pop_back());
            end
        end else if (st && !e.full) begin
            m_addr.push_back(a);
            m_data.push_back(d);
        end
    endtask

    task automatic st_op(input logic [31:0] a, input logic [31:0] d, input string tag);
        step(1'b1, a, d, 0, 1'b0, a, 1'b0, tag);
    endtask

    task automatic look(input logic [31:0] la, input string tag);
        step(1'b0, '0, '0, 0, 1'b0, la, 1'b0, tag);
    endtask

    // Commit everything outstanding and drain until the model is empty (bounded).
    task automatic settle();
        int unc;
        for (int k = 0; k < 20 && m_addr.size() > 0; k++) begin
            unc = m_addr.size() - m_ncom;
            step(1'b0, '0, '0, (unc > 2) ? 2 : unc, 1'b0, '0, 1'b0, "settle");
        end
    endtask

    // Scoreboard monitor: one expectation per driven cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({sbif.o_stbuf_full, sbif.o_stbuf_addr_hit, sbif.o_stbuf_rd_data,
                     sbif.o_dmem_we, sbif.o_dmem_wr_addr, sbif.o_dmem_wr_data} !==
                    {e.full, e.hit, e.rd, e.we, e.wa, e.wd}) begin
                    errors++;
                    $display("FAIL %s: got full=%0b hit=%0b rd=%h we=%0b wa=%h wd=%h, want full=%0b hit=%0b rd=%h we=%0b wa=%h wd=%h",
                             e.tag, sbif.o_stbuf_full, sbif.o_stbuf_addr_hit, sbif.o_stbuf_rd_data,
                             sbif.o_dmem_we, sbif.o_dmem_wr_addr, sbif.o_dmem_wr_data,
                             e.full, e.hit, e.rd, e.we, e.wa, e.wd);
                end
            end
        end
    end

    initial begin
        int unc;
        int cn;
        rst_n  = 1'b1;
        m_ncom = 0;
        idle_inputs();
        #2 rst_n = 1'b0;

        rst_cycle("reset0");

        // Reset asserted while two entries are live.
        st_op(32'h100, 32'h11, "pre_rst0");
        st_op(32'h104, 32'h22, "pre_rst1");
        rst_cycle("reset_mid");
        look(32'h100, "idle_after_rst");

        // Fill to full, then a store while full is ignored.
        for (int i = 0; i < 4; i++) begin
            st_op(32'h100 + 32'(4 * i), 32'h1000 + 32'(i), "fill");
        end
        step(1'b1, 32'h110, 32'hDEAD, 0, 1'b0, 32'h10C, 1'b0, "st_when_full");
        look(32'h110, "ignored_store");

        // Commit two, hold the port for two cycles, then drain back to back.
        step(1'b0, '0, '0, 2, 1'b0, 32'h100, 1'b0, "commit2");
        step(1'b0, '0, '0, 0, 1'b0, 32'h100, 1'b1, "occupied1");
        step(1'b0, '0, '0, 0, 1'b0, 32'h104, 1'b1, "occupied2");
        step(1'b0, '0, '0, 0, 1'b0, 32'h100, 1'b0, "drain0");
        step(1'b0, '0, '0, 0, 1'b0, 32'h100, 1'b0, "drain1");
        settle();

        // Youngest match wins; miss gives zero data.
        st_op(32'h200, 32'hAAAA, "fwd_st0");
        st_op(32'h200, 32'hBBBB, "fwd_st1");
        look(32'h200, "fwd_young");
        look(32'h204, "fwd_miss");
        settle();

        // Kill with same-cycle commit of one entry and a dropped allocation.
        st_op(32'h400, 32'h40, "kill_st0");
        st_op(32'h404, 32'h44, "kill_st1");
        st_op(32'h408, 32'h48, "kill_st2");
        step(1'b1, 32'h40C, 32'h4C, 1, 1'b1, 32'h408, 1'b1, "kill");
        step(1'b0, '0, '0, 0, 1'b0, 32'h404, 1'b1, "kill_gone");
        step(1'b0, '0, '0, 0, 1'b0, 32'h40C, 1'b1, "kill_dropped");
        step(1'b0, '0, '0, 0, 1'b0, 32'h400, 1'b1, "kill_kept");
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h410 + 32'(4 * i), 32'h50 + 32'(i), 0, 1'b0, 32'h400, 1'b1, "kill_refill");
        end
        step(1'b0, '0, '0, 0, 1'b0, 32'h410, 1'b1, "kill_full");
        settle();

        // Wrap-around: repeated store/commit/drain with a second entry resident.
        st_op(32'h5FC, 32'h5F, "wrap_pre");
        for (int it = 0; it < 10; it++) begin
            st_op(32'h500 + 32'(4 * it), $urandom, "wrap_st");
            step(1'b0, '0, '0, 1, 1'b0, 32'h500 + 32'(4 * it), 1'b0, "wrap_commit");
            step(1'b0, '0, '0, 0, 1'b0, 32'h500 + 32'(4 * it), 1'b0, "wrap_drain");
        end
        settle();

        // Random traffic against the model.
        for (int n = 0; n < 800; n++) begin
            unc = m_addr.size() - m_ncom;
            cn  = $urandom_range(0, (unc > 2) ? 2 : unc);
            step($urandom_range(0, 99) < 55, 32'h300 + 32'(4 * $urandom_range(0, 7)), $urandom,
                 cn, $urandom_range(0, 99) < 4, 32'h300 + 32'(4 * $urandom_range(0, 7)),
                 $urandom_range(0, 99) < 30, "random");
            if ($urandom_range(0, 299) == 0) begin
                rst_cycle("random_rst");
            end
        end

        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_scoreboard: got %0d pending, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
